ws_array_dbuf: RTL and testbench

//   Parametrised ROWSxCOLS weight-stationary systolic MAC array: next generation of the fixed 16x16 array.

---
 rtl/ws_array_dbuf.sv | 169 ++++++++++++++++
 tb/tb_ws_array_dbuf.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws_array_dbuf.sv
// ws_array_dbuf: a ROWS x COLS weight-stationary systolic MAC array with double-buffered weights.
//
// An activation beat is accepted on the input valid/ready handshake. Row r sees the beat's data
// r cycles after acceptance. The partial sums and a valid tag move down the array one row per
// cycle. The complete result for all columns appears at psum_out, with out_valid high, ROWS
// cycles after the beat was accepted.
//
// Weights are written one column at a time into a shadow bank. weight_swap copies the shadow
// bank into the active bank. Before the copy, the array stops accepting beats and waits for all
// beats in flight to drain, so every beat is computed with a single consistent weight set.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   input beat handshake
//   data_in             ROWS signed activations; slice r goes to row r
//   weight_wr_en/_col   write shadow column weight_wr_col; indices >= COLS are ignored
//   weight_wr_data      ROWS signed weights for that column; slice r goes to row r
//   weight_swap         request a shadow->active copy (pulse, honoured only in RUN)
//   swap_done           one-cycle pulse after the copy edge
//   out_valid/psum_out  result strobe and COLS signed partial sums
//   busy                at least one beat is in flight
module ws_array_dbuf #(
    parameter int ROWS       = 16,
    parameter int COLS       = 16,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int COL_AW     = $clog2(COLS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ROWS*DATA_WIDTH-1:0] data_in,
    input  logic                       weight_wr_en,
    input  logic [COL_AW-1:0]          weight_wr_col,
    input  logic [ROWS*DATA_WIDTH-1:0] weight_wr_data,
    input  logic                       weight_swap,
    output logic                       swap_done,
    output logic                       out_valid,
    output logic [COLS*ACC_WIDTH-1:0]  psum_out,
    output logic                       busy
);

    localparam int IFW = $clog2(ROWS + 1);

    localparam logic [1:0] ST_RUN       = 2'd0;
    localparam logic [1:0] ST_SWAP_WAIT = 2'd1;
    localparam logic [1:0] ST_SWAP_DONE = 2'd2;

    logic [1:0]                 r_state;
    logic [1:0]                 w_state_d;
    logic [IFW-1:0]             r_inflight;
    logic                       w_accept;
    logic                       w_copy;
    logic                       w_wr_ok;
    logic [ROWS*DATA_WIDTH-1:0] w_x_in;

    logic [DATA_WIDTH-1:0] r_w_sh  [ROWS][COLS];
    logic [DATA_WIDTH-1:0] r_w_act [ROWS][COLS];
    logic [DATA_WIDTH-1:0] w_row_x [ROWS];
    logic [ROWS-1:0]       r_vld;
    logic [ACC_WIDTH-1:0]  r_psum  [ROWS][COLS];

    // Sign-extend both operands to the accumulator width.
    // The low ACC_WIDTH bits of the product are then the two's-complement wrapped result.
    function automatic logic [ACC_WIDTH-1:0] f_mac(input logic [ACC_WIDTH-1:0]  p,
                                                   input logic [DATA_WIDTH-1:0] x,
                                                   input logic [DATA_WIDTH-1:0] w);
        logic [ACC_WIDTH-1:0] xe;
        logic [ACC_WIDTH-1:0] we;
        xe = {{(ACC_WIDTH - DATA_WIDTH){x[DATA_WIDTH-1]}}, x};
        we = {{(ACC_WIDTH - DATA_WIDTH){w[DATA_WIDTH-1]}}, w};
        return p + xe * we;
    endfunction

    // Control: handshake, drain-before-copy FSM
    always_comb begin
        in_ready  = (r_state == ST_RUN) && !weight_swap;
        w_accept  = in_valid && in_ready;
        w_copy    = (r_state == ST_SWAP_WAIT) && (r_inflight == '0);
        swap_done = (r_state == ST_SWAP_DONE);
        busy      = (r_inflight != '0);
        w_wr_ok   = weight_wr_en && (int'(weight_wr_col) < COLS);
        // A cycle without an accepted beat injects a zero bubble.
        w_x_in    = w_accept ? data_in : '0;
        w_state_d = r_state;
        case (r_state)
            ST_RUN:       if (weight_swap) w_state_d = ST_SWAP_WAIT;
            ST_SWAP_WAIT: if (w_copy) w_state_d = ST_SWAP_DONE;
            ST_SWAP_DONE: w_state_d = ST_RUN;
            default:      w_state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_inflight <= '0;
        end else begin
            r_state <= w_state_d;
            case ({w_accept, out_valid})
                2'b10:   r_inflight <= r_inflight + IFW'(1);
                2'b01:   r_inflight <= r_inflight - IFW'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // Weight banks. On the copy edge, active takes the old shadow contents.
    // A write on that same edge updates only the shadow bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w_sh  <= '{default: '0};
            r_w_act <= '{default: '0};
        end else begin
            if (w_copy) begin
                r_w_act <= r_w_sh;
            end
            if (w_wr_ok) begin
                for (int r = 0; r < ROWS; r++) begin
                    r_w_sh[r][weight_wr_col] <= weight_wr_data[r*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Input skew: row r's activation passes through r delay registers.
    assign w_row_x[0] = w_x_in[DATA_WIDTH-1:0];

    for (genvar g = 1; g < ROWS; g++) begin : g_skew
        logic [DATA_WIDTH-1:0] r_sk [g];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sk <= '{default: '0};
            end else begin
                r_sk[0] <= w_x_in[g*DATA_WIDTH +: DATA_WIDTH];
                for (int k = 1; k < g; k++) begin
                    r_sk[k] <= r_sk[k-1];
                end
            end
        end
        assign w_row_x[g] = r_sk[g-1];
    end

    // PE grid: partial sums and the valid tag move down one row per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld  <= '0;
            r_psum <= '{default: '0};
        end else begin
            r_vld <= {r_vld[ROWS-2:0], w_accept};
            for (int c = 0; c < COLS; c++) begin
                r_psum[0][c] <= f_mac('0, w_row_x[0], r_w_act[0][c]);
                for (int r = 1; r < ROWS; r++) begin
                    r_psum[r][c] <= f_mac(r_psum[r-1][c], w_row_x[r], r_w_act[r][c]);
                end
            end
        end
    end

    always_comb begin
        out_valid = r_vld[ROWS-1];
        psum_out  = '0;
        for (int c = 0; c < COLS; c++) begin
            psum_out[c*ACC_WIDTH +: ACC_WIDTH] = r_psum[ROWS-1][c];
        end
    end

endmodule

// File: tb/tb_ws_array_dbuf.sv
module tb_ws_array_dbuf;

    localparam int ROWS = 16;
    localparam int COLS = 12;
    localparam int DW   = 8;
    localparam int ACC  = 18;
    localparam int CAW  = 4;
    localparam int XW   = ROWS * DW;
    localparam int PW   = COLS * ACC;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [XW-1:0] data_in = '0;
    logic          weight_wr_en = 1'b0;
    logic [CAW-1:0] weight_wr_col = '0;
    logic [XW-1:0] weight_wr_data = '0;
    logic          weight_swap = 1'b0;
    logic          swap_done;
    logic          out_valid;
    logic [PW-1:0] psum_out;
    logic          busy;

    ws_array_dbuf #(
        .ROWS       (ROWS),
        .COLS       (COLS),
        .DATA_WIDTH (DW),
        .ACC_WIDTH  (ACC),
        .COL_AW     (CAW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .data_in        (data_in),
        .weight_wr_en   (weight_wr_en),
        .weight_wr_col  (weight_wr_col),
        .weight_wr_data (weight_wr_data),
        .weight_swap    (weight_swap),
        .swap_done      (swap_done),
        .out_valid      (out_valid),
        .psum_out       (psum_out),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [PW-1:0] ps;
        int            at;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

    // Reference state: weight matrices as plain integers plus handshake timing bookkeeping.
    int sh_m  [ROWS][COLS];
    int act_m [ROWS][COLS];
    int rdy_cyc   = 0;
    int last_acc  = -1000;
    int copy_edge = -1;
    int exp_done  = -1;

    task automatic chk1(input string nm, input logic a, input logic e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0b want %0b", nm, cyc, a, e);
        end
    endtask

    task automatic chkv(input string nm, input logic [PW-1:0] a, input logic [PW-1:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", nm, cyc, a, e);
        end
    endtask

    task automatic chki(input string nm, input int a, input int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, a, e);
        end
    endtask

    // result[c] = sum_r x[r] * W[r][c], wrapped to ACC bits
    function automatic logic [PW-1:0] golden(input logic [XW-1:0] x);
        logic [PW-1:0] res;
        longint        s;
        res = '0;
        for (int c = 0; c < COLS; c++) begin
            s = 0;
            for (int r = 0; r < ROWS; r++) begin
                s += longint'($signed(x[r*DW +: DW])) * longint'(act_m[r][c]);
            end
            res[c*ACC +: ACC] = s[ACC-1:0];
        end
        return res;
    endfunction

    function automatic logic [XW-1:0] rnd_vec();
        logic [XW-1:0] v;
        for (int r = 0; r < ROWS; r++) v[r*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    // One clock cycle of stimulus. Entered and left at posedge+1.
    task automatic cyc_drive(input logic v, input logic [XW-1:0] x, input logic sw,
                             input logic we, input int col, input logic [XW-1:0] wd);
        int   e;
        logic run;
        logic er;
        e = cyc;
        in_valid       = v;
        data_in        = x;
        weight_swap    = sw;
        weight_wr_en   = we;
        weight_wr_col  = col[CAW-1:0];
        weight_wr_data = wd;
        run = (e >= rdy_cyc);
        er  = run && !sw;
        @(negedge clk);
        chk1("in_ready", in_ready, er);
        chk1("busy", busy, e < last_acc + ROWS);
        if (v && er) begin
            sbq.push_back('{ps: golden(x), at: e + ROWS});
            last_acc = e + 1;
        end
        if (sw && run) begin
            copy_edge = ((e + 1 > last_acc + ROWS) ? e + 1 : last_acc + ROWS) + 1;
            exp_done  = copy_edge;
            rdy_cyc   = copy_edge + 1;
        end
        if (e + 1 == copy_edge) act_m = sh_m;
        if (we && col < COLS) begin
            for (int r = 0; r < ROWS; r++) sh_m[r][col] = int'($signed(wd[r*DW +: DW]));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc_drive(1'b0, '0, 1'b0, 1'b0, 0, '0);
    endtask

    task automatic wr_col(input int col, input logic [XW-1:0] d);
        cyc_drive(1'b0, '0, 1'b0, 1'b1, col, d);
    endtask

    task automatic beat(input logic [XW-1:0] x);
        cyc_drive(1'b1, x, 1'b0, 1'b0, 0, '0);
    endtask

    // Swap request with in_valid held high; optionally also write a shadow column on the copy edge.
    task automatic do_swap(input logic wr_copy, input int col, input logic [XW-1:0] d);
        cyc_drive(1'b1, rnd_vec(), 1'b1, 1'b0, 0, '0);
        while (cyc <= exp_done) begin
            cyc_drive(1'b1, rnd_vec(), 1'b0, wr_copy && (cyc + 1 == copy_edge), col, d);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk1({tag, "_out_valid"}, out_valid, 1'b0);
        chk1({tag, "_swap_done"}, swap_done, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_in_ready"}, in_ready, 1'b1);
        chkv({tag, "_psum_out"}, psum_out, '0);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected out_valid at cycle %0d", cyc);
            end else begin
                mon_e = sbq.pop_front();
                chki("out_cycle", cyc, mon_e.at);
                chkv("psum", psum_out, mon_e.ps);
            end
        end
        if (rst_n && (swap_done || cyc == exp_done)) begin
            chki("swap_done_cycle", swap_done ? cyc : -1, exp_done);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [XW-1:0] v;
        sh_m  = '{default: 0};
        act_m = '{default: 0};

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Identity weights; col COLS must be ignored.
        for (int c = 0; c < COLS; c++) begin
            v = '0;
            v[c*DW +: DW] = DW'(1);
            wr_col(c, v);
        end
        wr_col(COLS, {ROWS{8'h07}});
        do_swap(1'b0, 0, '0);
        for (int r = 0; r < ROWS; r++) v[r*DW +: DW] = DW'(r + 1);
        beat(v);
        idle(ROWS + 2);

        // All -128: 16 * 16384 = 2^18 wraps to 0 in 18 bits.
        for (int c = 0; c < COLS; c++) wr_col(c, {ROWS{8'h80}});
        do_swap(1'b0, 0, '0);
        beat({ROWS{8'h80}});
        idle(ROWS + 2);

        // 20 back-to-back random beats.
        for (int c = 0; c < COLS; c++) wr_col(c, rnd_vec());
        do_swap(1'b0, 0, '0);
        for (int i = 0; i < 20; i++) beat(rnd_vec());
        idle(ROWS + 2);

        // Swap under load; a write on the copy edge must land only in the shadow bank.
        for (int i = 0; i < 5; i++) beat(rnd_vec());
        for (int c = 0; c < COLS; c++) wr_col(c, rnd_vec());
        do_swap(1'b1, 3, rnd_vec());
        beat(rnd_vec());
        beat(rnd_vec());
        do_swap(1'b0, 0, '0);
        beat(rnd_vec());
        idle(ROWS + 2);

        // Random mix of beats, writes (including out-of-range columns) and swaps.
        for (int i = 0; i < 120; i++) begin
            cyc_drive(($urandom % 4) != 0, rnd_vec(), ($urandom % 25) == 0,
                      ($urandom % 3) == 0, $urandom_range(0, 15), rnd_vec());
        end
        idle(ROWS + 4);

        // Reset with beats in flight: nothing may come out afterwards.
        for (int i = 0; i < 3; i++) beat(rnd_vec());
        in_valid     = 1'b0;
        weight_swap  = 1'b0;
        weight_wr_en = 1'b0;
        rst_n        = 1'b0;
        #2;
        check_reset_outputs("midreset");
        sbq.delete();
        sh_m      = '{default: 0};
        act_m     = '{default: 0};
        rdy_cyc   = 0;
        last_acc  = -1000;
        copy_edge = -1;
        exp_done  = -1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(ROWS + 3);
        beat(rnd_vec());
        idle(ROWS + 2);

        chki("scoreboard_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
